irq_ctrl: RTL and testbench
===========================

IRQ_CTRL -- requirements
Module: irq_ctrl

Interface
REQ-001 The block SHALL have one clock, `clk`: input, 1 bit, rising-edge.
REQ-002 The block SHALL have one reset, `reset`: input, 1 bit, asynchronous, active-low; 0 = reset asserted.
REQ-003 `irq_src`: input, 6 bits; level interrupt lines; bit 0 is the timer-counter irq.
REQ-004 `resetirq`: output, 6 bits; one-cycle clear pulse returned to each source.
REQ-005 `addr`: input, 32 bits; register select uses addr[3:2].
REQ-006 `we`: input, 1 bit; register write strobe.
REQ-007 `din`: input, 32 bits; write data. `dout`: output, 32 bits; read data.
REQ-008 `int_req`: output, 1 bit; interrupt request to the CPU.
REQ-009 `int_ack`: input, 1 bit; the CPU takes the interrupt this cycle.
REQ-010 `pc_in`: input, 32 bits; return PC, sampled on ack.
REQ-011 `eret`: input, 1 bit; the CPU returns from the handler.

Function
REQ-012 Register map by addr[3:2] SHALL be:
- 00 SR: {16'b0, IM[15:10], 8'b0, EXL[1], IE[0]}.
- 01 CAUSE: {16'b0, IP[15:10], 5'b0, CODE[4:2], 2'b0}.
- 10 EPC.
- 11 PRID, constant 32'h0000_0100.
Unlisted bits SHALL read 0.
REQ-013 `dout` SHALL be combinational from addr[3:2] and current register state, with no latency.
REQ-014 SR writes SHALL update IM, EXL and IE only. EPC writes SHALL load all 32 bits. PRID writes SHALL be ignored.
REQ-015 CAUSE writes SHALL be write-1-to-clear on IP: for each i with din[10+i]=1, pending[i] clears at that edge. CODE SHALL not be writable.
REQ-016 `resetirq[i]` SHALL be 1 for exactly the cycle after the edge that clears pending[i] via CAUSE, and 0 otherwise.
REQ-017 pending[i] SHALL set at any edge where irq_src[i]=1, except during the two edges starting with its clear edge (clear edge N and edge N+1). In that window irq_src[i] SHALL be ignored, so the source can deassert.
REQ-018 Clear SHALL win over a simultaneous set at the clear edge.
REQ-019 Eligible = IE & ~EXL & |(pending & IM).
REQ-020 The FSM SHALL have three states: IDLE, REQ, SERVICE.
- IDLE -> REQ at the edge where eligible=1.
- REQ -> SERVICE on int_ack=1.
- REQ -> IDLE if eligible=0 and int_ack=0.
- SERVICE -> IDLE on eret=1.
REQ-021 `int_req` SHALL be 1 exactly while state=REQ, registered. It SHALL first assert the cycle after eligible rises, and deassert the cycle after ack.
REQ-022 At the ack edge, the block SHALL perform all of the following:
- EPC <= pc_in.
- EXL <= 1.
- CODE <= index of the lowest-numbered bit of (pending & IM); bit 0 is highest priority.
REQ-023 int_ack outside REQ SHALL be ignored.
REQ-024 At the eret edge in SERVICE, EXL <= 0. eret in IDLE or REQ SHALL be ignored.
REQ-025 Ack and SR write in the same cycle: ack SHALL win for EXL; IM and IE SHALL take the written value.
REQ-026 Eret and SR write in the same cycle: eret SHALL win for EXL.
REQ-027 Ack and EPC write in the same cycle: the ack capture SHALL win.
REQ-028 pending bits SHALL stay latched in SERVICE. No new int_req SHALL issue until EXL=0.

Reset
REQ-029 While reset=0, the block SHALL hold all of the following, regardless of clk:
- SR = 0, pending = 0, CODE = 0, EPC = 0.
- clear-window flags = 0.
- state = IDLE, int_req = 0, resetirq = 0.
REQ-030 Reset asserted mid-REQ or mid-SERVICE SHALL drop int_req within the same cycle. A request SHALL re-issue only after software re-enables IE.
REQ-031 The first edge after reset deasserts SHALL behave as a normal IDLE cycle.

Verification
REQ-032 The bench SHALL cover these directed scenarios:
- Reset, then read all four addresses -> 0, 0, 0, 32'h0000_0100.
- SR <= 32'h0000_0401 (IM0, IE); irq_src[0]=1 at edge N -> int_req=1 after edge N+1; ack with pc_in=32'h0000_3014 -> EPC=32'h0000_3014, SR reads 32'h0000_0403, CODE=0, int_req=0 next cycle.
- In SERVICE, write CAUSE with din=32'h0000_0400 -> resetirq=6'b000001 for one cycle; source drops; IP reads 0; eret -> EXL=0, no new int_req.
- irq_src=6'b101000 with IM=all ones -> CODE=3 at ack; after clearing bit 3 and eret, the next request gives CODE=5.
- In REQ, write SR IM=0 before ack -> int_req falls next cycle and state returns to IDLE; a later ack is ignored.
- Assert reset during SERVICE -> int_req=0 and SR/EPC=0 immediately; eret afterwards has no effect.

Source files
------------

// File: rtl/irq_ctrl.sv
// -----------------------------------------------------------------------------
// irq_ctrl -- six-line interrupt controller with an SR/CAUSE/EPC/PRID register
// file and a three-state request handshake toward the CPU.
//
// Ports
//   clk       rising-edge clock
//   reset     asynchronous, active-low reset (0 = held in reset)
//   irq_src   [5:0]  level interrupt lines, bit 0 = timer-counter (highest prio)
//   resetirq  [5:0]  one-cycle clear pulse back to each source
//   addr      [31:0] register select on addr[3:2]
//   we               register write strobe
//   din       [31:0] write data
//   dout      [31:0] combinational read data
//   int_req          interrupt request to the CPU (high while in REQ)
//   int_ack          CPU takes the interrupt this cycle
//   pc_in     [31:0] return PC, captured into EPC on ack
//   eret             CPU returns from the handler
//
// Register map (addr[3:2])
//   00 SR    {16'b0, IM[15:10], 8'b0, EXL[1], IE[0]}
//   01 CAUSE {16'b0, IP[15:10], 5'b0, CODE[4:2], 2'b0}   IP is write-1-to-clear
//   10 EPC
//   11 PRID  32'h0000_0100 (read-only)
// -----------------------------------------------------------------------------
module irq_ctrl (
   input  logic        clk,
   input  logic        reset,
   input  logic [5:0]  irq_src,
   output logic [5:0]  resetirq,
   input  logic [31:0] addr,
   input  logic        we,
   input  logic [31:0] din,
   output logic [31:0] dout,
   output logic        int_req,
   input  logic        int_ack,
   input  logic [31:0] pc_in,
   input  logic        eret
);

   localparam logic [31:0] PRID = 32'h0000_0100;

   typedef enum logic [1:0] {
      IDLE,
      REQ,
      SERVICE
   } state_t;

   state_t      state, state_nxt;

   logic [5:0]  im;
   logic        exl;
   logic        ie;
   logic [5:0]  pending;
   logic [5:0]  clr_win;   // source was cleared at the previous edge; ignore it once more
   logic [2:0]  code;
   logic [31:0] epc;

   logic        sr_wr, cause_wr, epc_wr;
   logic        ack_take, eret_take, eligible;
   logic [5:0]  clr, pend_hit;
   logic [2:0]  hit_idx;

   // Only addr[3:2] selects a register; the rest of the bus is don't-care.
   logic unused_addr_bits;
   assign unused_addr_bits = ^{addr[31:4], addr[1:0]};

   assign sr_wr     = we && (addr[3:2] == 2'b00);
   assign cause_wr  = we && (addr[3:2] == 2'b01);
   assign epc_wr    = we && (addr[3:2] == 2'b10);
   assign clr       = cause_wr ? din[15:10] : 6'b0;

   // Ack and eret only count in the state that expects them.
   assign ack_take  = (state == REQ)     && int_ack;
   assign eret_take = (state == SERVICE) && eret;

   assign pend_hit  = pending & im;
   assign eligible  = ie && !exl && (|pend_hit);

   // Lowest-numbered pending-and-enabled line wins; scanning downward lets the
   // lowest index overwrite any higher one.
   always_comb begin
      // NOTE: every variable written in a combinational block gets a default
      // first, so no path leaves it unassigned and no latch is inferred.
      hit_idx = 3'd0;
      for (int i = 5; i >= 0; i--) begin
         if (pend_hit[i]) hit_idx = 3'(i);
      end
   end

   // ---------------------------------------------------------------- FSM
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (eligible) state_nxt = REQ;
         REQ: begin
            if (int_ack)        state_nxt = SERVICE;
            else if (!eligible) state_nxt = IDLE;
         end
         SERVICE: if (eret)     state_nxt = IDLE;
         default:               state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state <= IDLE;
      // NOTE: sequential state uses non-blocking assignments so every flop
      // samples pre-edge values regardless of statement order.
      else        state <= state_nxt;
   end

   // int_req is a pure decode of the state flop, so it is registered and
   // drops the moment reset forces IDLE.
   assign int_req = (state == REQ);

   // ---------------------------------------------------------- registers
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         im       <= 6'b0;
         exl      <= 1'b0;
         ie       <= 1'b0;
         pending  <= 6'b0;
         clr_win  <= 6'b0;
         resetirq <= 6'b0;
         code     <= 3'd0;
         epc      <= 32'b0;
      end else begin
         if (sr_wr) begin
            im <= din[15:10];
            ie <= din[0];
         end

         // Ack/eret override a same-cycle SR write of EXL.
         if (ack_take)       exl <= 1'b1;
         else if (eret_take) exl <= 1'b0;
         else if (sr_wr)     exl <= din[1];

         // The ack capture overrides a same-cycle EPC write.
         if (ack_take)    epc <= pc_in;
         else if (epc_wr) epc <= din;

         if (ack_take) code <= hit_idx;

         // A clear beats a simultaneous set; the source is then ignored for
         // one further edge so the device has time to drop its line.
         pending  <= (pending | (irq_src & ~clr_win)) & ~clr;
         clr_win  <= clr;
         resetirq <= clr;
      end
   end

   // ---------------------------------------------------------- read port
   always_comb begin
      dout = 32'b0;
      case (addr[3:2])
         2'b00:   dout = {16'b0, im, 8'b0, exl, ie};
         2'b01:   dout = {16'b0, pending, 5'b0, code, 2'b0};
         2'b10:   dout = epc;
         default: dout = PRID;
      endcase
   end

endmodule

// File: tb/tb_irq_ctrl.sv
// -----------------------------------------------------------------------------
// tb_irq_ctrl -- directed scenarios followed by randomized traffic, all
// compared against a behavioural model of the interrupt controller.
// -----------------------------------------------------------------------------
module tb_irq_ctrl;

   logic        clk;
   logic        reset;
   logic [5:0]  irq_src;
   logic [5:0]  resetirq;
   logic [31:0] addr;
   logic        we;
   logic [31:0] din;
   logic [31:0] dout;
   logic        int_req;
   logic        int_ack;
   logic [31:0] pc_in;
   logic        eret;

   irq_ctrl dut (
      .clk      (clk),
      .reset    (reset),
      .irq_src  (irq_src),
      .resetirq (resetirq),
      .addr     (addr),
      .we       (we),
      .din      (din),
      .dout     (dout),
      .int_req  (int_req),
      .int_ack  (int_ack),
      .pc_in    (pc_in),
      .eret     (eret)
   );

   initial clk = 1'b0;
   always #10 clk = ~clk;

   int n_chk = 0;
   int n_err = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
      end
   endtask

   // ------------------------------------------------------ reference model
   typedef enum int {PH_IDLE, PH_REQ, PH_SVC} phase_t;

   phase_t      m_phase;
   logic [5:0]  m_im, m_pend, m_rirq;
   logic        m_ie, m_exl;
   logic [2:0]  m_code;
   logic [31:0] m_epc;
   int          m_ign [6];   // edges still to ignore each source after a clear

   task automatic model_reset();
      m_phase = PH_IDLE;
      m_im = '0; m_pend = '0; m_rirq = '0;
      m_ie = 1'b0; m_exl = 1'b0; m_code = '0; m_epc = '0;
      for (int i = 0; i < 6; i++) m_ign[i] = 0;
   endtask

   // One rising edge, using the inputs currently being driven.
   task automatic model_step();
      bit         sr_w, ca_w, ep_w, ack, er, elig, found;
      logic [5:0] masked;
      int         lowest;
      sr_w   = we && (addr[3:2] == 2'd0);
      ca_w   = we && (addr[3:2] == 2'd1);
      ep_w   = we && (addr[3:2] == 2'd2);
      masked = m_pend & m_im;
      elig   = m_ie && !m_exl && (masked != 6'b0);
      ack    = (m_phase == PH_REQ) && int_ack;
      er     = (m_phase == PH_SVC) && eret;
      lowest = 0;
      found  = 0;
      for (int i = 0; i < 6; i++) begin
         if (!found && masked[i]) begin
            lowest = i;
            found  = 1;
         end
      end

      case (m_phase)
         PH_IDLE: if (elig) m_phase = PH_REQ;
         PH_REQ:  if (int_ack) m_phase = PH_SVC; else if (!elig) m_phase = PH_IDLE;
         default: if (eret) m_phase = PH_IDLE;
      endcase

      if (sr_w) begin
         m_im  = din[15:10];
         m_ie  = din[0];
         m_exl = din[1];
      end
      if (ack) m_exl = 1'b1;
      if (er)  m_exl = 1'b0;
      if (ep_w) m_epc = din;
      if (ack) begin
         m_epc  = pc_in;
         m_code = 3'(lowest);
      end

      for (int i = 0; i < 6; i++) begin
         if (ca_w && din[10+i]) begin
            m_pend[i] = 1'b0;
            m_ign[i]  = 1;
            m_rirq[i] = 1'b1;
         end else begin
            if (irq_src[i] && m_ign[i] == 0) m_pend[i] = 1'b1;
            if (m_ign[i] > 0) m_ign[i]--;
            m_rirq[i] = 1'b0;
         end
      end
   endtask

   function automatic logic [31:0] exp_dout(input int sel);
      case (sel)
         0:       return {16'b0, m_im, 8'b0, m_exl, m_ie};
         1:       return {16'b0, m_pend, 5'b0, m_code, 2'b0};
         2:       return m_epc;
         default: return 32'h0000_0100;
      endcase
   endfunction

   // ------------------------------------------------------- bench helpers
   task automatic tick();
      logic [31:0] save;
      @(posedge clk);
      model_step();
      #1;
      check("int_req", 32'(int_req), 32'(m_phase == PH_REQ));
      check("resetirq", 32'(resetirq), 32'(m_rirq));
      save = addr;
      for (int a = 0; a < 4; a++) begin
         addr = {save[31:4], 2'(a), save[1:0]};
         #1;
         check($sformatf("dout_%0d", a), dout, exp_dout(a));
      end
      addr = save;
   endtask

   task automatic set_idle();
      we = 1'b0; addr = '0; din = '0; int_ack = 1'b0; eret = 1'b0; pc_in = '0;
   endtask

   task automatic wr(input int sel, input logic [31:0] data);
      set_idle();
      addr = 32'(sel) << 2;
      we   = 1'b1;
      din  = data;
      tick();
      we   = 1'b0;
   endtask

   task automatic chk_reg(input string tag, input int sel, input logic [31:0] exp);
      logic [31:0] save;
      save = addr;
      addr = 32'(sel) << 2;
      #1;
      check(tag, dout, exp);
      addr = save;
   endtask

   task automatic wait_req();
      int n = 0;
      while (!int_req && n < 8) begin
         tick();
         n++;
      end
      check("wait_req", 32'(int_req), 32'd1);
   endtask

   task automatic ack(input logic [31:0] pc);
      set_idle();
      int_ack = 1'b1;
      pc_in   = pc;
      tick();
      int_ack = 1'b0;
   endtask

   task automatic do_eret();
      set_idle();
      eret = 1'b1;
      tick();
      eret = 1'b0;
   endtask

   // ------------------------------------------------------------ stimulus
   initial begin
      reset   = 1'b0;
      irq_src = '0;
      set_idle();
      model_reset();
      repeat (3) @(posedge clk);
      @(negedge clk);
      reset = 1'b1;

      // Reset values of the four registers.
      check("rst_int_req", 32'(int_req), 32'd0);
      check("rst_resetirq", 32'(resetirq), 32'd0);
      chk_reg("rst_sr", 0, 32'h0);
      chk_reg("rst_cause", 1, 32'h0);
      chk_reg("rst_epc", 2, 32'h0);
      chk_reg("rst_prid", 3, 32'h0000_0100);

      // Timer irq: request two edges after the source rises, then ack.
      wr(0, 32'h0000_0401);
      irq_src = 6'b000001;
      tick();
      check("req_not_yet", 32'(int_req), 32'd0);
      tick();
      check("req_up", 32'(int_req), 32'd1);
      ack(32'h0000_3014);
      check("req_down", 32'(int_req), 32'd0);
      chk_reg("ack_epc", 2, 32'h0000_3014);
      chk_reg("ack_sr", 0, 32'h0000_0403);
      chk_reg("ack_cause", 1, 32'h0000_0400);

      // Clear in SERVICE while the source is still high: clear wins.
      wr(1, 32'h0000_0400);
      check("clr_pulse", 32'(resetirq), 32'h01);
      chk_reg("clr_ip", 1, 32'h0);
      irq_src = '0;
      tick();
      check("clr_pulse_end", 32'(resetirq), 32'h0);
      chk_reg("clr_ip_hold", 1, 32'h0);
      do_eret();
      chk_reg("eret_sr", 0, 32'h0000_0401);
      repeat (3) begin
         tick();
         check("no_new_req", 32'(int_req), 32'd0);
      end

      // Priority: bits 3 and 5 pending, all enabled.
      wr(0, 32'h0000_FC01);
      irq_src = 6'b101000;
      tick();
      irq_src = '0;
      wait_req();
      ack(32'h0000_4000);
      chk_reg("prio_cause3", 1, 32'h0000_A00C);
      wr(1, 32'h0000_2000);
      do_eret();
      wait_req();
      ack(32'h0000_4004);
      chk_reg("prio_cause5", 1, 32'h0000_8014);
      wr(1, 32'h0000_8000);
      do_eret();

      // Mask in REQ withdraws the request; a late ack is ignored.
      wr(0, 32'h0000_0401);
      irq_src = 6'b000001;
      tick();
      irq_src = '0;
      wait_req();
      wr(0, 32'h0000_0001);
      tick();
      check("mask_drop", 32'(int_req), 32'd0);
      ack(32'hDEAD_BEEF);
      chk_reg("late_ack_epc", 2, 32'h0000_4004);
      chk_reg("late_ack_sr", 0, 32'h0000_0001);
      wr(1, 32'h0000_0400);

      // Reset during SERVICE.
      wr(0, 32'h0000_0401);
      irq_src = 6'b000001;
      tick();
      irq_src = '0;
      wait_req();
      ack(32'h0000_5000);
      reset = 1'b0;
      #1;
      model_reset();
      check("mid_rst_req", 32'(int_req), 32'd0);
      chk_reg("mid_rst_sr", 0, 32'h0);
      chk_reg("mid_rst_epc", 2, 32'h0);
      reset = 1'b1;
      do_eret();
      chk_reg("post_rst_sr", 0, 32'h0);
      check("post_rst_req", 32'(int_req), 32'd0);

      // Randomized traffic.
      for (int it = 0; it < 3000; it++) begin
         we      = ($urandom_range(0, 3) == 0);
         addr    = $urandom;
         din     = $urandom;
         if (addr[3:2] == 2'd0) begin
            din[0] = ($urandom_range(0, 3) != 0);
            din[1] = ($urandom_range(0, 3) == 0);
         end
         for (int b = 0; b < 6; b++) irq_src[b] = ($urandom_range(0, 3) == 0);
         int_ack = ($urandom_range(0, 2) == 0);
         eret    = ($urandom_range(0, 3) == 0);
         pc_in   = $urandom;
         if ($urandom_range(0, 149) == 0) begin
            reset = 1'b0;
            #1;
            model_reset();
            check("rnd_rst_req", 32'(int_req), 32'd0);
            check("rnd_rst_rirq", 32'(resetirq), 32'd0);
            reset = 1'b1;
         end
         tick();
      end

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
